// File: rtl/spi_pwm_cfg_ctrl_if.sv
// SPI pin bundle between an SPI master (host / testbench) and the
// configuration controller.
//   sclk : SPI clock, idle low
//   copi : SPI data, MSB first, sampled on rising sclk
//   ncs  : chip select, active low
interface spi_pwm_cfg_ctrl_if;
    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/spi_pwm_cfg_ctrl.sv
// SPI-mode-0, write-only configuration controller for the PWM peripheral.
// The SPI pins are synchronised into clk, 16-bit write frames are decoded
// and each valid frame is committed into one of five 8-bit config registers.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   spi (slave)      sclk / copi / ncs pins, asynchronous to clk
//   en_reg_out_7_0   addr 0x00     en_reg_out_15_8  addr 0x01
//   en_reg_pwm_7_0   addr 0x02     en_reg_pwm_15_8  addr 0x03
//   pwm_duty_cycle   addr 0x04
//   wr_pulse         one-clk strobe when a register is written
//   frame_err        one-clk strobe when a frame ends with a wrong bit count
module spi_pwm_cfg_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BITS  = 16,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_pwm_cfg_ctrl_if.slave     spi,
    output logic [7:0]            en_reg_out_7_0,
    output logic [7:0]            en_reg_out_15_8,
    output logic [7:0]            en_reg_pwm_7_0,
    output logic [7:0]            en_reg_pwm_15_8,
    output logic [7:0]            pwm_duty_cycle,
    output logic                  wr_pulse,
    output logic                  frame_err
);

    localparam int         NUM_REGS = 5;
    // Pin vector ordering: [2]=ncs, [1]=copi, [0]=sclk. Idle: ncs=1, sclk=0.
    localparam logic [2:0] PIN_IDLE = 3'b100;
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers, history flop and registered edge strobes
    // ------------------------------------------------------------------
    logic [2:0] pin_raw;
    logic [2:0] sync_reg [SYNC_STAGES];
    logic [2:0] pin_s;
    logic [2:0] hist_reg;
    logic       sclk_rise_reg;
    logic       ncs_rise_reg;
    logic       ncs_fall_reg;

    assign pin_raw = {spi.ncs, spi.copi, spi.sclk};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= PIN_IDLE;
                end else if (gi == 0) begin
                    sync_reg[gi] <= pin_raw;
                end else begin
                    sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign pin_s = sync_reg[SYNC_STAGES-1];

    // Edges are registered, so copi is taken from the history flop: it holds
    // the copi_s value that was present when the sclk rise was detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg      <= PIN_IDLE;
            sclk_rise_reg <= 1'b0;
            ncs_rise_reg  <= 1'b0;
            ncs_fall_reg  <= 1'b0;
        end else begin
            hist_reg      <= pin_s;
            sclk_rise_reg <= pin_s[0] & ~hist_reg[0];
            ncs_rise_reg  <= pin_s[2] & ~hist_reg[2];
            ncs_fall_reg  <= ~pin_s[2] & hist_reg[2];
        end
    end

    // ------------------------------------------------------------------
    // Arming: after reset the synchronisers hold forced idle values, so a
    // falling ncs edge only counts once a genuine high ncs has been seen.
    // This keeps a chip select that was already low at reset release from
    // starting a frame.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] flush_reg;
    logic                   armed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_reg <= '0;
            armed_reg <= 1'b0;
        end else begin
            flush_reg <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
            if (flush_reg[SYNC_STAGES-1] && pin_s[2]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                  state_reg, state_next;
    logic [FRAME_BITS-1:0]   shreg_reg, shreg_next;
    logic [4:0]              bitcnt_reg, bitcnt_next;
    logic                    wr_pulse_reg, wr_pulse_next;
    logic                    frame_err_reg, frame_err_next;
    logic [6:0]              frame_addr;
    logic [7:0]              frame_data;

    assign frame_addr = shreg_reg[FRAME_BITS-2:8];
    assign frame_data = shreg_reg[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            bitcnt_reg    <= '0;
            wr_pulse_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            bitcnt_reg    <= bitcnt_next;
            wr_pulse_reg  <= wr_pulse_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        bitcnt_next    = bitcnt_reg;
        wr_pulse_next  = 1'b0;
        frame_err_next = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (ncs_fall_reg && armed_reg) begin
                    state_next  = SHIFT;
                    shreg_next  = '0;
                    bitcnt_next = '0;
                end
            end
            SHIFT: begin
                // End of frame wins over a coincident sclk edge.
                if (ncs_rise_reg) begin
                    state_next = COMMIT;
                end else if (sclk_rise_reg) begin
                    shreg_next = {shreg_reg[FRAME_BITS-2:0], hist_reg[1]};
                    if (bitcnt_reg != CNT_SAT) begin
                        bitcnt_next = bitcnt_reg + 5'd1;
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
                if (bitcnt_reg == CNT_FULL) begin
                    wr_pulse_next = shreg_reg[FRAME_BITS-1] && (frame_addr <= MAX_ADDR);
                end else begin
                    frame_err_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Config registers: written on the same edge that leaves COMMIT
    // ------------------------------------------------------------------
    logic [7:0] cfg_reg [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
            always_ff @(posedge clk) begin
                if (rst) begin
                    cfg_reg[gi] <= 8'h00;
                end else if (wr_pulse_next && (frame_addr == 7'(gi))) begin
                    cfg_reg[gi] <= frame_data;
                end
            end
        end
    endgenerate

    assign en_reg_out_7_0  = cfg_reg[0];
    assign en_reg_out_15_8 = cfg_reg[1];
    assign en_reg_pwm_7_0  = cfg_reg[2];
    assign en_reg_pwm_15_8 = cfg_reg[3];
    assign pwm_duty_cycle  = cfg_reg[4];
    assign wr_pulse        = wr_pulse_reg;
    assign frame_err       = frame_err_reg;

endmodule

// File: tb/tb_spi_pwm_cfg_ctrl.sv
// Self-checking bench for spi_pwm_cfg_ctrl: table of SPI frames with
// expected register contents and strobe counts, plus hand sequences for
// reset, commit latency, mid-frame reset and ncs-low-at-reset.
module tb_spi_pwm_cfg_ctrl;

    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_pulse;
    logic       frame_err;

    spi_pwm_cfg_ctrl_if spi_if ();

    spi_pwm_cfg_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .FRAME_BITS  (16),
        .MAX_ADDR    (7'h04)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi_if.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_pulse        (wr_pulse),
        .frame_err       (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of clk cycles each strobe is high (sampled mid-cycle).
    int wr_cnt  = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (wr_pulse)  wr_cnt  <= wr_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] regs_now();
        return {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle};
    endfunction

    task automatic check_regs(input string tag, input logic [39:0] exp);
        logic [39:0] act;
        act = regs_now();
        check({tag, " out_7_0"},  act[39:32], exp[39:32]);
        check({tag, " out_15_8"}, act[31:24], exp[31:24]);
        check({tag, " pwm_7_0"},  act[23:16], exp[23:16]);
        check({tag, " pwm_15_8"}, act[15:8],  exp[15:8]);
        check({tag, " duty"},     act[7:0],   exp[7:0]);
    endtask

    // Drive ncs low and shift nbits of data MSB first; sclk high/low = 3 clks.
    task automatic send_bits(input logic [16:0] data, input int nbits);
        spi_if.ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_if.copi = data[i];
            repeat (3) @(negedge clk);
            spi_if.sclk = 1'b1;
            repeat (3) @(negedge clk);
            spi_if.sclk = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic end_frame();
        spi_if.ncs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [16:0] data;
        int          nbits;
        logic [39:0] exp_regs;   // {out_7_0, out_15_8, pwm_7_0, pwm_15_8, duty}
        int          exp_wr;
        int          exp_err;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int wr0, err0, k;
        logic [16:0] v;

        vecs[0]  = '{"w_duty_55",   17'h08455, 16, 40'h00_00_00_00_55, 1, 0};
        vecs[1]  = '{"w_out_lo_F0", 17'h080F0, 16, 40'hF0_00_00_00_55, 1, 0};
        vecs[2]  = '{"w_out_hi_FF", 17'h081FF, 16, 40'hF0_FF_00_00_55, 1, 0};
        vecs[3]  = '{"w_pwm_lo_03", 17'h08203, 16, 40'hF0_FF_03_00_55, 1, 0};
        vecs[4]  = '{"read_0412",   17'h00412, 16, 40'hF0_FF_03_00_55, 0, 0};
        vecs[5]  = '{"badaddr_87",  17'h08712, 16, 40'hF0_FF_03_00_55, 0, 0};
        v = 17'h08499;
        vecs[6]  = '{"short_15",    v >> 1,    15, 40'hF0_FF_03_00_55, 0, 1};
        vecs[7]  = '{"long_17",     {v[15:0], 1'b1}, 17, 40'hF0_FF_03_00_55, 0, 1};
        vecs[8]  = '{"w_pwm_hi_77", 17'h08377, 16, 40'hF0_FF_03_77_55, 1, 0};
        vecs[9]  = '{"w_duty_AA",   17'h084AA, 16, 40'hF0_FF_03_77_AA, 1, 0};
        vecs[10] = '{"w_duty_BB",   17'h084BB, 16, 40'hF0_FF_03_77_BB, 1, 0};

        spi_if.sclk = 1'b0;
        spi_if.copi = 1'b0;
        spi_if.ncs  = 1'b1;
        rst = 1'b1;

        // Reset held for 2 clks
        @(negedge clk);
        wr0 = wr_cnt; err0 = err_cnt;
        repeat (2) @(negedge clk);
        check_regs("reset", 40'h0);
        check("reset wr_pulse",  wr_pulse,  1'b0);
        check("reset frame_err", frame_err, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("post_reset strobes", {wr_cnt - wr0, err_cnt - err0}, 64'h0);
        $display("reset: regs=0x%010h", regs_now());

        // Table-driven frames
        for (int i = 0; i < 11; i++) begin
            wr0 = wr_cnt; err0 = err_cnt;
            send_bits(vecs[i].data, vecs[i].nbits);
            end_frame();
            check_regs(vecs[i].name, vecs[i].exp_regs);
            check({vecs[i].name, " wr_cycles"},  64'(wr_cnt - wr0),   64'(vecs[i].exp_wr));
            check({vecs[i].name, " err_cycles"}, 64'(err_cnt - err0), 64'(vecs[i].exp_err));
            $display("frame %s bits=%0d: regs=0x%010h wr=%0d err=%0d",
                     vecs[i].name, vecs[i].nbits, regs_now(), wr_cnt - wr0, err_cnt - err0);
        end

        // Commit latency: wr_pulse visible after edge SYNC_STAGES+2 counted
        // from the first edge that samples ncs high (that edge is k=0).
        wr0 = wr_cnt;
        send_bits(17'h08422, 16);
        spi_if.ncs = 1'b1;
        k = -1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (wr_pulse) begin
                k = j;
                break;
            end
        end
        check("latency edges", 64'(k), 64'(SYNC_STAGES + 2));
        check("latency duty", pwm_duty_cycle, 8'h22);
        repeat (12) @(negedge clk);
        check("latency wr_cycles", 64'(wr_cnt - wr0), 64'd1);
        $display("latency: wr_pulse after %0d edges, duty=0x%02h", k, pwm_duty_cycle);

        // Reset after 8 bits of 0x8433; the partial frame is lost
        send_bits(17'h00084, 8);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_regs("midreset", 40'h0);
        rst = 1'b0;
        wr0 = wr_cnt; err0 = err_cnt;
        repeat (4) @(negedge clk);
        end_frame();
        check("midreset ncs_release strobes", {wr_cnt - wr0, err_cnt - err0}, 64'h0);
        send_bits(17'h08466, 16);
        end_frame();
        check_regs("after_midreset", 40'h00_00_00_00_66);
        check("after_midreset wr_cycles",  64'(wr_cnt - wr0),   64'd1);
        check("after_midreset err_cycles", 64'(err_cnt - err0), 64'd0);
        $display("midreset: regs=0x%010h", regs_now());

        // ncs already low when reset releases: the clocked-in frame is ignored
        spi_if.ncs = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        wr0 = wr_cnt; err0 = err_cnt;
        send_bits(17'h08411, 16);
        end_frame();
        check_regs("ncs_low_at_reset", 40'h0);
        check("ncs_low_at_reset strobes", {wr_cnt - wr0, err_cnt - err0}, 64'h0);
        // A fresh frame afterwards works again
        send_bits(17'h08099, 16);
        end_frame();
        check_regs("after_ncs_low", 40'h99_00_00_00_00);
        $display("ncs_low_at_reset: regs=0x%010h", regs_now());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
